// File: rtl/alu_station_pkg.sv
// Shared constants for the ALU reservation station: aluc groups, tag width, flag bit order.
package alu_station_pkg;

    localparam int unsigned DEF_TAG_W = 4;
    localparam int unsigned DATA_W    = 32;

    // aluc[3:2] selects the operation group.
    typedef enum logic [1:0] {
        AlucAddSub = 2'b00,
        AlucLogic  = 2'b01,
        AlucLuiSlt = 2'b10,
        AlucShift  = 2'b11
    } aluc_grp_e;

    // out_flags = {zero, carry, negative, overflow}
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_V = 0;

    function automatic logic [3:0] pack_flags(input logic z, input logic c,
                                              input logic n, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_N] = n;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_station_pick.sv
// Combinational priority picker: grants the lowest-index request.
module rs_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_gnt,
    output logic         o_any
);

    // Isolate the lowest set bit.
    assign o_gnt = i_req & (~i_req + N'(1));
    assign o_any = |i_req;

endmodule

// File: rtl/alu_station.sv
// Four-entry collapsing-queue reservation station feeding a combinational ALU,
// with CDB wakeup and a registered valid/ready output slot.
module alu_station #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = alu_station_pkg::DEF_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_aluc,
    input  logic [TAG_W-1:0] in_dtag,
    input  logic             in_a_rdy,
    input  logic             in_b_rdy,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_a_tag,
    input  logic [TAG_W-1:0] in_b_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_aluc,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_negative,
    input  logic             alu_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic [31:0]      out_data,
    output logic [3:0]       out_flags
);
    import alu_station_pkg::*;

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [CW-1:0]    r_count;
    logic [3:0]       r_aluc  [DEPTH];
    logic [TAG_W-1:0] r_dtag  [DEPTH];
    logic [DEPTH-1:0] r_a_rdy, r_b_rdy;
    logic [TAG_W-1:0] r_a_tag [DEPTH];
    logic [TAG_W-1:0] r_b_tag [DEPTH];
    logic [31:0]      r_a_val [DEPTH];
    logic [31:0]      r_b_val [DEPTH];

    logic [3:0]       w_aluc_d  [DEPTH];
    logic [TAG_W-1:0] w_dtag_d  [DEPTH];
    logic [DEPTH-1:0] w_a_rdy_d, w_b_rdy_d;
    logic [TAG_W-1:0] w_a_tag_d [DEPTH];
    logic [TAG_W-1:0] w_b_tag_d [DEPTH];
    logic [31:0]      w_a_val_d [DEPTH];
    logic [31:0]      w_b_val_d [DEPTH];
    logic [IW-1:0]    w_src     [DEPTH];

    logic             r_out_valid;
    logic [TAG_W-1:0] r_out_tag;
    logic [31:0]      r_out_data;
    logic [3:0]       r_out_flags;

    logic [DEPTH-1:0] w_req, w_gnt;
    logic             w_issue, w_accept, w_slot_free;
    logic [IW-1:0]    w_idx;
    logic [CW-1:0]    w_wr, w_count_d;
    logic             w_in_a_rdy, w_in_b_rdy;
    logic [31:0]      w_in_a_val, w_in_b_val;

    assign in_ready    = (r_count < CW'(DEPTH));
    assign w_accept    = in_valid & in_ready;
    assign w_slot_free = ~r_out_valid | out_ready;

    always_comb begin
        w_req = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_req[i] = (CW'(i) < r_count) & r_a_rdy[i] & r_b_rdy[i] & w_slot_free;
        end
    end

    rs_pick #(.N(DEPTH)) u_pick (
        .i_req (w_req),
        .o_gnt (w_gnt),
        .o_any (w_issue)
    );

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_gnt[i]) w_idx = IW'(i);
        end
    end

    assign alu_a    = r_a_val[w_idx];
    assign alu_b    = r_b_val[w_idx];
    assign alu_aluc = r_aluc[w_idx];

    assign w_wr      = r_count - CW'(w_issue);
    assign w_count_d = r_count + CW'(w_accept) - CW'(w_issue);

    // Dispatch bypass: a same-cycle CDB broadcast fills a tagged operand on write.
    assign w_in_a_rdy = in_a_rdy | (cdb_valid & (in_a_tag == cdb_tag));
    assign w_in_b_rdy = in_b_rdy | (cdb_valid & (in_b_tag == cdb_tag));
    assign w_in_a_val = in_a_rdy ? in_a : cdb_data;
    assign w_in_b_val = in_b_rdy ? in_b : cdb_data;

    // Entries at or above the issued index take their upper neighbour.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_src[i] = IW'(i);
            if (w_issue && (IW'(i) >= w_idx) && (i < DEPTH - 1)) w_src[i] = IW'(i + 1);
        end
    end

    always_comb begin
        w_a_rdy_d = '0;
        w_b_rdy_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_aluc_d[i]  = r_aluc[w_src[i]];
            w_dtag_d[i]  = r_dtag[w_src[i]];
            w_a_tag_d[i] = r_a_tag[w_src[i]];
            w_b_tag_d[i] = r_b_tag[w_src[i]];
            w_a_rdy_d[i] = r_a_rdy[w_src[i]];
            w_b_rdy_d[i] = r_b_rdy[w_src[i]];
            w_a_val_d[i] = r_a_val[w_src[i]];
            w_b_val_d[i] = r_b_val[w_src[i]];
            if (cdb_valid && !r_a_rdy[w_src[i]] && (r_a_tag[w_src[i]] == cdb_tag)) begin
                w_a_rdy_d[i] = 1'b1;
                w_a_val_d[i] = cdb_data;
            end
            if (cdb_valid && !r_b_rdy[w_src[i]] && (r_b_tag[w_src[i]] == cdb_tag)) begin
                w_b_rdy_d[i] = 1'b1;
                w_b_val_d[i] = cdb_data;
            end
            if (w_accept && (CW'(i) == w_wr)) begin
                w_aluc_d[i]  = in_aluc;
                w_dtag_d[i]  = in_dtag;
                w_a_tag_d[i] = in_a_tag;
                w_b_tag_d[i] = in_b_tag;
                w_a_rdy_d[i] = w_in_a_rdy;
                w_b_rdy_d[i] = w_in_b_rdy;
                w_a_val_d[i] = w_in_a_val;
                w_b_val_d[i] = w_in_b_val;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count     <= '0;
            r_a_rdy     <= '0;
            r_b_rdy     <= '0;
            r_out_valid <= 1'b0;
            r_out_tag   <= '0;
            r_out_data  <= '0;
            r_out_flags <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_aluc[i]  <= '0;
                r_dtag[i]  <= '0;
                r_a_tag[i] <= '0;
                r_b_tag[i] <= '0;
                r_a_val[i] <= '0;
                r_b_val[i] <= '0;
            end
        end else if (flush) begin
            r_count     <= '0;
            r_a_rdy     <= '0;
            r_b_rdy     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_count <= w_count_d;
            r_a_rdy <= w_a_rdy_d;
            r_b_rdy <= w_b_rdy_d;
            for (int i = 0; i < DEPTH; i++) begin
                r_aluc[i]  <= w_aluc_d[i];
                r_dtag[i]  <= w_dtag_d[i];
                r_a_tag[i] <= w_a_tag_d[i];
                r_b_tag[i] <= w_b_tag_d[i];
                r_a_val[i] <= w_a_val_d[i];
                r_b_val[i] <= w_b_val_d[i];
            end
            if (w_issue) begin
                r_out_valid <= 1'b1;
                r_out_data  <= alu_result;
                r_out_tag   <= r_dtag[w_idx];
                r_out_flags <= pack_flags(alu_zero, alu_carry, alu_negative, alu_overflow);
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_tag   = r_out_tag;
    assign out_data  = r_out_data;
    assign out_flags = r_out_flags;

endmodule

// File: tb/tb_alu_station.sv
// Directed self-checking bench for alu_station with a small behavioural ALU.
module tb_alu_station;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [3:0]  in_aluc, in_dtag, in_a_tag, in_b_tag, cdb_tag, out_tag, alu_aluc, out_flags;
    logic        in_a_rdy, in_b_rdy, cdb_valid, out_valid, out_ready;
    logic [31:0] in_a, in_b, cdb_data, alu_a, alu_b, alu_result, out_data;
    logic        alu_zero, alu_carry, alu_negative, alu_overflow;
    logic [32:0] sum;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural ALU: 0000 add, 0100 and, 0101 or, else xor.
    always_comb begin
        sum          = {1'b0, alu_a} + {1'b0, alu_b};
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        case (alu_aluc)
            4'b0000: begin
                alu_result = sum[31:0];
                alu_carry  = sum[32];
            end
            4'b0100: alu_result = alu_a & alu_b;
            4'b0101: alu_result = alu_a | alu_b;
            default: alu_result = alu_a ^ alu_b;
        endcase
        alu_zero     = (alu_result == 32'd0);
        alu_negative = alu_result[31];
    end

    alu_station dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_aluc      (in_aluc),
        .in_dtag      (in_dtag),
        .in_a_rdy     (in_a_rdy),
        .in_b_rdy     (in_b_rdy),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_a_tag     (in_a_tag),
        .in_b_tag     (in_b_tag),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_aluc     (alu_aluc),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_carry    (alu_carry),
        .alu_negative (alu_negative),
        .alu_overflow (alu_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_tag      (out_tag),
        .out_data     (out_data),
        .out_flags    (out_flags)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic disp(input logic [3:0] aluc, input logic [3:0] dtag,
                        input logic ardy, input logic [31:0] a, input logic [3:0] atag,
                        input logic brdy, input logic [31:0] b);
        in_valid = 1'b1;
        in_aluc  = aluc;
        in_dtag  = dtag;
        in_a_rdy = ardy;
        in_a     = a;
        in_a_tag = atag;
        in_b_rdy = brdy;
        in_b     = b;
        in_b_tag = 4'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_aluc = '0; in_dtag = '0; in_a_rdy = 1'b0; in_b_rdy = 1'b0;
        in_a = '0; in_b = '0; in_a_tag = '0; in_b_tag = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_data",  out_data,       32'd0);
        chk("rst_out_tag",   32'(out_tag),   32'd0);
        chk("rst_out_flags", 32'(out_flags), 32'd0);
        rst = 1'b0;

        // Ready dispatch: 3 + 5
        disp(4'b0000, 4'd2, 1'b1, 32'd3, 4'd0, 1'b1, 32'd5);
        tick(); in_valid = 1'b0;
        chk("t1_not_yet", 32'(out_valid), 32'd0);
        tick();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data",  out_data,       32'd8);
        chk("t1_tag",   32'(out_tag),   32'd2);
        chk("t1_flags", 32'(out_flags), 32'h0);
        tick();
        chk("t1_drain", 32'(out_valid), 32'd0);

        // Wakeup: and with a tagged 7
        disp(4'b0100, 4'd3, 1'b0, 32'd0, 4'd7, 1'b1, 32'h0F);
        tick(); in_valid = 1'b0;
        tick();
        chk("t2_wait", 32'(out_valid), 32'd0);
        cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_data = 32'hF0;
        tick(); cdb_valid = 1'b0;
        chk("t2_wake_edge", 32'(out_valid), 32'd0);
        tick();
        chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_data",  out_data,       32'd0);
        chk("t2_flags", 32'(out_flags), 32'h8);
        chk("t2_tag",   32'(out_tag),   32'd3);
        tick();

        // Same-cycle bypass on dispatch
        disp(4'b0000, 4'd4, 1'b0, 32'd0, 4'd5, 1'b1, 32'd1);
        cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_data = 32'd9;
        tick(); in_valid = 1'b0; cdb_valid = 1'b0;
        tick();
        chk("t3_valid", 32'(out_valid), 32'd1);
        chk("t3_data",  out_data,       32'd10);
        chk("t3_tag",   32'(out_tag),   32'd4);
        tick();

        // Order / full: oldest blocked on tag 3, slot backpressured while filling
        out_ready = 1'b0;
        disp(4'b0000, 4'd8, 1'b0, 32'd0, 4'd3, 1'b1, 32'd1);
        tick();
        disp(4'b0000, 4'd9, 1'b1, 32'd10, 4'd0, 1'b1, 32'd1);
        tick();
        disp(4'b0000, 4'd10, 1'b1, 32'd20, 4'd0, 1'b1, 32'd1);
        tick();
        chk("t4_first_valid", 32'(out_valid), 32'd1);
        chk("t4_first_data",  out_data,       32'd11);
        disp(4'b0000, 4'd11, 1'b1, 32'd30, 4'd0, 1'b1, 32'd1);
        tick();
        disp(4'b0000, 4'd12, 1'b1, 32'd40, 4'd0, 1'b1, 32'd1);
        tick(); in_valid = 1'b0;
        chk("t4_full_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("t4_issue_alu_a", alu_a, 32'd20);
        chk("t4_ready_during_issue", 32'(in_ready), 32'd0);
        tick();
        chk("t4_e2_data", out_data, 32'd21);
        chk("t4_e2_tag",  32'(out_tag), 32'd10);
        chk("t4_ready_rise", 32'(in_ready), 32'd1);
        tick();
        chk("t4_e3_data", out_data, 32'd31);
        chk("t4_e3_tag",  32'(out_tag), 32'd11);
        cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_data = 32'd100;
        tick(); cdb_valid = 1'b0;
        chk("t4_e4_data", out_data, 32'd41);
        chk("t4_e4_tag",  32'(out_tag), 32'd12);
        tick();
        chk("t4_e0_data", out_data, 32'd101);
        chk("t4_e0_tag",  32'(out_tag), 32'd8);
        tick();
        chk("t4_drain", 32'(out_valid), 32'd0);

        // Backpressure: two ready entries, out_ready low
        out_ready = 1'b0;
        disp(4'b0000, 4'd1, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1);
        tick();
        disp(4'b0000, 4'd5, 1'b1, 32'd2, 4'd0, 1'b1, 32'd2);
        tick(); in_valid = 1'b0;
        tick();
        chk("t5_hold_data", out_data, 32'd2);
        chk("t5_hold_tag",  32'(out_tag), 32'd1);
        tick();
        chk("t5_hold_data2", out_data, 32'd2);
        chk("t5_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("t5_next_data", out_data, 32'd4);
        chk("t5_next_tag",  32'(out_tag), 32'd5);
        tick();
        chk("t5_drain", 32'(out_valid), 32'd0);

        // Flush with 3 entries and a held result
        out_ready = 1'b0;
        disp(4'b0000, 4'd6, 1'b1, 32'd5, 4'd0, 1'b1, 32'd5);
        tick();
        disp(4'b0000, 4'd7, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1);
        tick();
        disp(4'b0000, 4'd13, 1'b1, 32'd2, 4'd0, 1'b1, 32'd2);
        tick();
        disp(4'b0000, 4'd14, 1'b1, 32'd3, 4'd0, 1'b1, 32'd3);
        tick(); in_valid = 1'b0;
        chk("t6_pre_valid", 32'(out_valid), 32'd1);
        chk("t6_pre_data",  out_data,       32'd10);
        flush = 1'b1; out_ready = 1'b1;
        disp(4'b0000, 4'd15, 1'b1, 32'd4, 4'd0, 1'b1, 32'd4);
        tick(); flush = 1'b0; in_valid = 1'b0;
        chk("t6_flush_valid", 32'(out_valid), 32'd0);
        chk("t6_flush_ready", 32'(in_ready),  32'd1);
        tick();
        chk("t6_empty1", 32'(out_valid), 32'd0);
        tick();
        chk("t6_empty2", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        disp(4'b0000, 4'd9, 1'b1, 32'd7, 4'd0, 1'b1, 32'd7);
        tick();
        disp(4'b0000, 4'd2, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1);
        tick(); in_valid = 1'b0;
        chk("t7_pre_data", out_data, 32'd14);
        #3 rst = 1'b1;
        #1;
        chk("t7_rst_valid", 32'(out_valid), 32'd0);
        chk("t7_rst_data",  out_data,       32'd0);
        chk("t7_rst_tag",   32'(out_tag),   32'd0);
        chk("t7_rst_ready", 32'(in_ready),  32'd1);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        tick(); tick();
        chk("t7_no_emit", 32'(out_valid), 32'd0);
        disp(4'b0000, 4'd1, 1'b1, 32'd2, 4'd0, 1'b1, 32'd3);
        tick(); in_valid = 1'b0;
        tick();
        chk("t7_after_data", out_data, 32'd5);
        chk("t7_after_tag",  32'(out_tag), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_station.md
# alu_station

Four-entry reservation station in the dynamic pipeline that sits ahead of the combinational ALU and drives its operand and control inputs. Dispatch writes decoded ALU ops into the station with operands either ready or tagged. The common data bus (CDB) is snooped to wake waiting operands. The oldest ready entry is issued to the ALU, and its result and flags are registered into an output slot that drains to the CDB arbiter over a valid/ready handshake.

## Interface
- DEPTH, 4: number of station entries (2..8).
- TAG_W, 4: width of producer tags.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous squash of all entries and the output slot.
- in_valid  in  1  dispatch request.
- in_ready  out  1  station can accept a dispatch.
- in_aluc  in  4  ALU operation code.
- in_dtag  in  TAG_W  destination tag of the op.
- in_a_rdy / in_b_rdy  in  1  operand value present.
- in_a / in_b  in  32  operand value (when rdy).
- in_a_tag / in_b_tag  in  TAG_W  producer tag (when not rdy).
- cdb_valid  in  1  CDB broadcast present.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_data  in  32  broadcast value.
- alu_a / alu_b  out  32  ALU operands.
- alu_aluc  out  4  ALU control.
- alu_result  in  32  ALU result (combinational from alu_*).
- alu_zero / alu_carry / alu_negative / alu_overflow  in  1  ALU flags.
- out_valid  out  1  output slot holds a result.
- out_ready  in  1  CDB arbiter takes the slot.
- out_tag  out  TAG_W  destination tag of the result.
- out_data  out  32  registered result.
- out_flags  out  4  {zero, carry, negative, overflow}, registered.

## Operation
- Entries are held in age order at indices 0..count-1 (a collapsing queue). Index 0 is the oldest.
- Each entry holds: aluc, dtag, and per-operand {rdy, tag, value}.
- in_ready = (count < DEPTH). It is registered-state only, with no same-cycle credit from an issue.
- A dispatch is accepted when in_valid & in_ready.
  - The new entry is written at index count, or at count-1 if an issue happens in the same cycle.
- Wakeup: every not-ready operand with tag == cdb_tag while cdb_valid captures cdb_data and sets rdy.
  - This also applies to the operands of the entry being dispatched in the same cycle (bypass on write).
- Issue condition: the entry has both rdy bits set, and the slot is free (!out_valid or out_ready).
  - The pick is the lowest-index entry that meets the condition.
- While an entry issues, alu_a/alu_b/alu_aluc carry its fields. When no entry issues, they hold the index-0 fields (value is don't-care).
- At the issue edge:
  - alu_result and the flags are captured into out_data/out_flags, out_tag = dtag, out_valid = 1.
  - The issued entry is removed and higher entries shift down one index.
- The output slot clears when out_valid & out_ready and nothing issues in that cycle.
- flush clears count and out_valid at the next edge and ignores any same-cycle dispatch or issue. flush has priority over all other events.
- The station does not interpret aluc. Flags are captured exactly as presented, including the ALU's held carry/overflow for ops that do not update them.

## Timing
- Reset values: count = 0, in_ready = 1, out_valid = 0, out_data = 0, out_tag = 0, out_flags = 0, all entry rdy bits = 0.
- A dispatch with both operands ready issues at the earliest one cycle later, and its result is out_valid two edges after acceptance.
- A CDB wakeup in cycle N allows issue in cycle N+1.
- Back-to-back: with out_ready held at 1, the station issues one op per cycle.
- Full (count = DEPTH): in_ready = 0 even if an issue occurs that cycle; it rises the cycle after.
- Empty: nothing issues, and the output slot holds or drains normally.
- out_ready = 0 with out_valid = 1: the slot and all entries hold. No issue, no data change.
- Asynchronous rst mid-operation returns everything to reset values immediately. No result is emitted after rst deasserts until a new dispatch.

## Structure
- The shared constants header holds:
  - aluc encodings: group 00 add/sub, 01 logic, 10 lui/slt, 11 shift.
  - TAG_W.
  - The out_flags bit order.
- One sub-module, rs_pick: a combinational priority picker (DEPTH ready bits in, one-hot grant plus any-valid out), also reused by later stations.

## Test plan
- Ready dispatch: aluc 0000, a = 3, b = 5, dtag 2 -> two edges later out_valid = 1, out_data = 8, out_tag = 2, zero = 0.
- Wakeup: dispatch aluc 0100 with a tagged 7 (not ready) and b = 0x0F. Then cdb_valid, tag 7, data 0xF0 -> out_data = 0, zero = 1, one cycle after the CDB cycle.
- Same-cycle bypass: dispatch with a_tag 5 while the CDB broadcasts tag 5 = 9, b = 1, aluc 0000 -> issues the next cycle, out_data = 10.
- Order/full: fill 4 entries with the oldest blocked on tag 3 -> in_ready = 0. Younger ready entries issue in age order. Waking tag 3 issues the oldest last, and in_ready rises one cycle after the first issue.
- Backpressure: hold out_ready = 0 with 2 ready entries -> the first result stays stable and nothing further issues. Releasing out_ready gives one result per cycle.
- flush/rst: assert flush with 3 entries and out_valid = 1 -> the next cycle count = 0 and out_valid = 0. Asserting rst mid-stream clears the outputs without waiting for a clock edge.
